// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared constants and types for the register file write arbiter
package regfile_ctrl_pkg;

    localparam int DATA_SIZE_D = 8;
    localparam int NUM_REG_D   = 4;
    localparam int NUM_REQ_D   = 3;

    typedef logic [NUM_REG_D-1:0]         reg_addr_t;
    typedef logic [$clog2(NUM_REQ_D)-1:0] req_id_t;

    // Index width for n requesters, never below one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal rotating priority pointer
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter  int N  = NUM_REQ_D,
    localparam int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] rr_ptr;
    logic          found;
    int            idx;

    // Search from rr_ptr upward with wrap; first valid requester wins
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = IW'(idx);
            end
        end
        gnt = (en && found) ? (N'(1) << gnt_id) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shared register file write port arbiter with hazard detect; REGFILE_BYPASS_EN adds forwarding
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter  int DATA_SIZE = DATA_SIZE_D,
    parameter  int NUM_REG   = NUM_REG_D,
    parameter  int NUM_REQ   = NUM_REQ_D,
    localparam int IW        = id_width(NUM_REQ)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         hold,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*NUM_REG-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REG-1:0]           WriteReg,
    output logic                         RegWriteCtrl,
    output logic [DATA_SIZE-1:0]         WriteData,
    output logic [IW-1:0]                grant_id,
    input  logic [NUM_REG-1:0]           srcA,
    input  logic [NUM_REG-1:0]           srcB,
    input  logic [DATA_SIZE-1:0]         rf_ReadA,
    input  logic [DATA_SIZE-1:0]         rf_ReadB,
    output logic [DATA_SIZE-1:0]         ReadA,
    output logic [DATA_SIZE-1:0]         ReadB,
    output logic                         hazard_a,
    output logic                         hazard_b
);

    logic [IW-1:0] win_id;
    logic          granted;
    logic          match_a;
    logic          match_b;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk    (CLK),
        .rst_n  (RST_N),
        .req    (req_valid),
        .en     (!hold),
        .gnt    (req_ready),
        .gnt_id (win_id)
    );

    assign granted = |req_ready;

    // One-deep write stage; on idle cycles only the enable drops, the rest holds
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RegWriteCtrl <= 1'b0;
            WriteReg     <= '0;
            WriteData    <= '0;
            grant_id     <= '0;
        end else begin
            RegWriteCtrl <= granted;
            if (granted) begin
                WriteReg  <= req_addr[int'(win_id)*NUM_REG +: NUM_REG];
                WriteData <= req_data[int'(win_id)*DATA_SIZE +: DATA_SIZE];
                grant_id  <= win_id;
            end
        end
    end

    assign match_a = RegWriteCtrl && (srcA == WriteReg);
    assign match_b = RegWriteCtrl && (srcB == WriteReg);

`ifdef REGFILE_BYPASS_EN
    assign ReadA    = match_a ? WriteData : rf_ReadA;
    assign ReadB    = match_b ? WriteData : rf_ReadB;
    assign hazard_a = 1'b0;
    assign hazard_b = 1'b0;
`else
    assign ReadA    = rf_ReadA;
    assign ReadB    = rf_ReadB;
    assign hazard_a = match_a;
    assign hazard_b = match_b;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int DS = 8;
    localparam int NR = 4;
    localparam int NQ = 3;
    localparam int IW = 2;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              hold = 1'b0;
    logic [NQ-1:0]     req_valid = '0;
    logic [NQ*NR-1:0]  req_addr = '0;
    logic [NQ*DS-1:0]  req_data = '0;
    logic [NQ-1:0]     req_ready;
    logic [NR-1:0]     WriteReg;
    logic              RegWriteCtrl;
    logic [DS-1:0]     WriteData;
    logic [IW-1:0]     grant_id;
    logic [NR-1:0]     srcA = '0;
    logic [NR-1:0]     srcB = '0;
    logic [DS-1:0]     rf_ReadA;
    logic [DS-1:0]     rf_ReadB;
    logic [DS-1:0]     ReadA;
    logic [DS-1:0]     ReadB;
    logic              hazard_a;
    logic              hazard_b;

    logic [DS-1:0]        rf [16];
    logic [NR+DS+IW-1:0]  exp_q [$];
    logic [NR+DS+IW-1:0]  exp_w;
    int                   n_checks = 0;
    int                   n_fail = 0;

    regfile_write_arbiter dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .WriteReg     (WriteReg),
        .RegWriteCtrl (RegWriteCtrl),
        .WriteData    (WriteData),
        .grant_id     (grant_id),
        .srcA         (srcA),
        .srcB         (srcB),
        .rf_ReadA     (rf_ReadA),
        .rf_ReadB     (rf_ReadB),
        .ReadA        (ReadA),
        .ReadB        (ReadB),
        .hazard_a     (hazard_a),
        .hazard_b     (hazard_b)
    );

    always #5 CLK = ~CLK;

    // Register file model behind the write port
    assign rf_ReadA = rf[srcA];
    assign rf_ReadB = rf[srcB];
    always @(posedge CLK) begin
        if (RegWriteCtrl) rf[WriteReg] <= WriteData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [NR-1:0] a, input logic [DS-1:0] d);
        req_addr[i*NR +: NR] = a;
        req_data[i*DS +: DS] = d;
    endtask

    task automatic push_exp(input int i);
        exp_q.push_back({req_addr[i*NR +: NR], req_data[i*DS +: DS], IW'(i)});
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    // Every cycle the write port is enabled must match the oldest granted request
    always @(negedge CLK) begin
        if (RST_N && RegWriteCtrl) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write observed=0x%0h expected=none",
                       {WriteReg, WriteData, grant_id});
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                chk("write_port", {18'd0, WriteReg, WriteData, grant_id}, {18'd0, exp_w});
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = {4'(i), 4'(i)};

        // Reset state
        at_neg();
        chk("rst_wen", RegWriteCtrl, 0);
        chk("rst_waddr", WriteReg, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        cyc();
        RST_N = 1'b1;

        // Reset while a write is staged: dropped, never committed
        set_req(0, 4'd3, 8'h5A);
        req_valid = 3'b001;
        at_neg();
        chk("rmw_ready", req_ready, 3'b001);
        cyc();
        chk("rmw_staged", RegWriteCtrl, 1);
        RST_N = 1'b0;
        req_valid = '0;
        #1;
        chk("rmw_drop_wen", RegWriteCtrl, 0);
        chk("rmw_drop_waddr", WriteReg, 0);
        cyc();
        cyc();
        RST_N = 1'b1;
        at_neg();
        chk("rmw_reg3", rf[3], 8'h33);

        // Round-robin fairness, pointer starts at 0 after reset
        cyc();
        for (int i = 0; i < NQ; i++) set_req(i, NR'(8 + i), DS'(16 * (i + 1)));
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            chk("rr_ready", req_ready, 32'(1 << (k % 3)));
            push_exp(k % 3);
            if (k > 0) chk("rr_wen", RegWriteCtrl, 1);
            cyc();
        end
        req_valid = '0;
        at_neg();
        chk("rr_wen_last", RegWriteCtrl, 1);
        cyc();
        at_neg();
        chk("rr_wen_off", RegWriteCtrl, 0);

        // Single write, visible in the register file two edges after grant
        cyc();
        set_req(1, 4'd5, 8'hC3);
        req_valid = 3'b010;
        at_neg();
        chk("single_ready", req_ready, 3'b010);
        push_exp(1);
        cyc();
        req_valid = '0;
        srcA = 4'd5;
        at_neg();
        cyc();
        at_neg();
        chk("single_readA", ReadA, 8'hC3);

        // Wrap and skip from pointer 2, then hold with req0/req2 pending
        cyc();
        set_req(0, 4'd1, 8'hA1);
        set_req(1, 4'd6, 8'hA6);
        req_valid = 3'b011;
        at_neg();
        chk("wrap_ready0", req_ready, 3'b001);
        push_exp(0);
        cyc();
        at_neg();
        chk("wrap_ready1", req_ready, 3'b010);
        push_exp(1);
        cyc();
        set_req(2, 4'd4, 8'h44);
        req_valid = 3'b101;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("hold_ready", req_ready, 0);
            if (k > 0) chk("hold_wen", RegWriteCtrl, 0);
            cyc();
        end
        hold = 1'b0;
        at_neg();
        chk("release_ready", req_ready, 3'b100);
        push_exp(2);
        cyc();
        req_valid = '0;
        at_neg();
        cyc();
        at_neg();
        chk("no_dup_wen", RegWriteCtrl, 0);
        chk("hold_reg4", rf[4], 8'h44);

        // Read hazard against the staged write
        cyc();
        set_req(0, 4'd7, 8'h11);
        req_valid = 3'b001;
        srcA = 4'd7;
        srcB = 4'd2;
        at_neg();
        chk("haz_ready", req_ready, 3'b001);
        push_exp(0);
        cyc();
        req_valid = '0;
        at_neg();
        chk("haz_b", hazard_b, 0);
        chk("haz_readB", ReadB, 8'h22);
`ifdef REGFILE_BYPASS_EN
        chk("haz_a", hazard_a, 0);
        chk("haz_readA", ReadA, 8'h11);
`else
        chk("haz_a", hazard_a, 1);
        chk("haz_readA", ReadA, 8'h77);
`endif
        cyc();
        at_neg();
        chk("haz_a_clear", hazard_a, 0);
        chk("haz_readA_commit", ReadA, 8'h11);

        cyc();
        at_neg();
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 2**NUM_REG-entry register file among NUM_REQ writeback requesters, e.g. ALU result, load result and debug/init.
- Round-robin arbitration with a valid/ready handshake per requester.
- Winner is registered into a one-deep write stage that drives the register file write port on the following cycle.
- Sits between read ports and datapath: flags read-after-write hazards against the staged write, and optionally forwards the staged data.

Parameters:
DATA_SIZE, 8, data width; must match the register file.
NUM_REG, 4, register address width (16 registers).
NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  reset, asynchronous, active-low.
hold  in  1  sequencer freeze; no new grants while high.
req_valid  in  NUM_REQ  per-requester write request.
req_addr  in  NUM_REQ*NUM_REG  packed destination addresses; requester i at slice i.
req_data  in  NUM_REQ*DATA_SIZE  packed write data.
req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready.
WriteReg  out  NUM_REG  register file write address.
RegWriteCtrl  out  1  register file write enable.
WriteData  out  DATA_SIZE  register file write data.
grant_id  out  $clog2(NUM_REQ)  index of requester owning the staged write.
srcA, srcB  in  NUM_REG  read addresses, also driven to the register file.
rf_ReadA, rf_ReadB  in  DATA_SIZE  raw register file read data.
ReadA, ReadB  out  DATA_SIZE  read data to the datapath.
hazard_a, hazard_b  out  1  read conflicts with the staged write.

Behaviour:
- Reset (async assert, sync release): RegWriteCtrl=0, WriteReg=0, WriteData=0, grant_id=0, rr_ptr=0. Any staged write is dropped, never committed.
- Arbitration (combinational):
  - Winner = first i with req_valid[i], searching from rr_ptr upward with modulo-NUM_REQ wrap.
  - req_ready is one-hot on the winner; all zero if hold=1 or no valid.
  - req_ready may depend on req_valid. Requesters must hold addr/data stable while valid and not ready.
- Grant at edge N: at most one per cycle.
  - Stage loads WriteReg/WriteData from the winner's slices, grant_id=winner, RegWriteCtrl=1 during cycle N+1.
  - Register file commits at edge N+1, so latency from grant to visible in rf_Read is 2 edges.
  - rr_ptr <= (winner+1) mod NUM_REQ.
- No grant at edge N: RegWriteCtrl=0 next cycle. WriteReg, WriteData and grant_id hold their values. rr_ptr unchanged.
- Throughput is 1 write/cycle. Back-to-back grants keep RegWriteCtrl continuously high.
- Same address from two requesters: serialized in grant order; last commit wins.
- hold=1: current staged write still completes, no new grant. Pending requesters keep valid; no loss, no duplication.
- Hazard: hazard_a = RegWriteCtrl && (srcA==WriteReg); hazard_b likewise. Both are 0 while RegWriteCtrl=0.
- Without bypass: ReadA=rf_ReadA, ReadB=rf_ReadB (pass-through).

Optional Feature:
Macro: REGFILE_BYPASS_EN.
- Defined: when srcA==WriteReg && RegWriteCtrl, ReadA=WriteData, and hazard_a is forced to 0. Same for B. Mux is combinational, no added latency.
- Undefined: pass-through reads, and hazard_a/hazard_b exactly as defined above so the sequencer stalls one cycle.

Decomposition:
- Package regfile_ctrl_pkg:
  - Default constants DATA_SIZE_D=8, NUM_REG_D=4, NUM_REQ_D=3.
  - typedef reg_addr_t = logic [NUM_REG_D-1:0].
  - typedef req_id_t = logic [$clog2(NUM_REQ_D)-1:0].
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, en, and the rr_ptr state.
  - Outputs: one-hot gnt and encoded gnt_id.
  - Holds rr_ptr internally, with async active-low reset.
- Top instantiates rr_arbiter plus the write stage and the hazard/bypass logic.

Test Plan:
- Reset mid-write: grant req0 (addr 3, data 0x5A), assert RST_N=0 before the next edge -> RegWriteCtrl=0 immediately, reg3 unchanged, rr_ptr=0 after release.
- Single write: req1 valid, addr 5, data 0xC3 -> req_ready=010 same cycle; next cycle RegWriteCtrl=1, WriteReg=5, WriteData=0xC3, grant_id=1; rf_ReadA(srcA=5)=0xC3 one cycle later.
- Round-robin fairness: all three valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; RegWriteCtrl high 6 consecutive cycles.
- Wrap and skip: rr_ptr=2, only req0 and req1 valid -> grant 0, then 1; rr_ptr ends at 2.
- hold: req2 valid, hold=1 for 3 cycles -> req_ready=000 and RegWriteCtrl=0 after the in-flight write; grant issued on the first cycle hold=0; exactly one write of req2's data.
- Hazard/bypass: staged write addr 7 data 0x11, srcA=7, srcB=2 -> hazard_a=1, hazard_b=0, ReadA=old reg7 (no macro); with REGFILE_BYPASS_EN -> hazard_a=0, ReadA=0x11.
